// File: rtl/jelly_img_demosaic_acpi_rb_calc.sv
// ACPI demosaic R/B stage: 6-deep pipeline producing R,G,B per Bayer site.
// Define JELLY_IMG_DEMOSAIC_ACPI_RB_ROUND_EN for round-half-up halving/quartering.
module jelly_img_demosaic_acpi_rb_calc #(
  parameter int DATA_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cke,
  input  logic [1:0]              param_phase,
  input  logic                    in_line_first,
  input  logic                    in_pixel_first,
  input  logic [9*DATA_WIDTH-1:0] in_raw,
  input  logic [9*DATA_WIDTH-1:0] in_g,
  output logic [DATA_WIDTH-1:0]   out_raw,
  output logic [DATA_WIDTH-1:0]   out_r,
  output logic [DATA_WIDTH-1:0]   out_g,
  output logic [DATA_WIDTH-1:0]   out_b
);

  localparam int W = DATA_WIDTH + 4;
  typedef logic signed [W-1:0] s_t;
  typedef logic [DATA_WIDTH-1:0] d_t;
  localparam s_t MAXV = s_t'((1 << DATA_WIDTH) - 1);

  function automatic s_t px(input logic [9*DATA_WIDTH-1:0] w,
                            input int i);
    return s_t'({{(W-DATA_WIDTH){1'b0}},
                 w[i*DATA_WIDTH +: DATA_WIDTH]});
  endfunction

  function automatic s_t ext(input d_t v);
    return s_t'({{(W-DATA_WIDTH){1'b0}}, v});
  endfunction

  function automatic s_t abs_s(input s_t v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic s_t div2(input s_t v);
`ifdef JELLY_IMG_DEMOSAIC_ACPI_RB_ROUND_EN
    return (v + s_t'(1)) >>> 1;
`else
    return v >>> 1;
`endif
  endfunction

  function automatic s_t div4(input s_t v);
`ifdef JELLY_IMG_DEMOSAIC_ACPI_RB_ROUND_EN
    return (v + s_t'(2)) >>> 2;
`else
    return v >>> 2;
`endif
  endfunction

  function automatic d_t clip(input s_t v);
    if (v < 0) return '0;
    if (v > MAXV) return '1;
    return v[DATA_WIDTH-1:0];
  endfunction

  logic x_q, y_q;
  logic x_c, y_c;

  logic [9*DATA_WIDTH-1:0] s1_raw, s1_g;
  logic [1:0] ph_d [1:5];
  d_t gc_d [2:5];
  d_t rc_d [2:5];

  s_t s2_dl, s2_dr, s2_du, s2_dd;
  s_t s2_d00, s2_d02, s2_d20, s2_d22;
  s_t s2_xn, s2_xp, s2_gn, s2_gp;

  s_t s3_h, s3_v, s3_sn, s3_sp;
  s_t s3_axn, s3_agn, s3_axp, s3_agp;

  s_t s4_h, s4_v, s4_sn, s4_sp;
  s_t s4_dn, s4_dp, s4_sa;

  s_t s5_th, s5_tv, s5_td;
  s_t td_c;

  s_t gcs;
  d_t v_h, v_v, v_d;
  d_t r_c, b_c;

  // phase of the sample entering this cycle
  always_comb begin
    x_c = in_pixel_first ? param_phase[0] : ~x_q;
    y_c = y_q;
    if (in_pixel_first) begin
      y_c = in_line_first ? param_phase[1] : ~y_q;
    end
  end

  always_comb begin
    td_c = div4(s4_sa);
    if (s4_dn < s4_dp) begin
      td_c = div2(s4_sn);
    end else if (s4_dn > s4_dp) begin
      td_c = div2(s4_sp);
    end
  end

  always_comb begin
    gcs = ext(gc_d[5]);
    v_h = clip(gcs + s5_th);
    v_v = clip(gcs + s5_tv);
    v_d = clip(gcs + s5_td);
    r_c = v_d;
    b_c = rc_d[5];
    unique case (ph_d[5])
      2'b00: begin
        r_c = rc_d[5];
        b_c = v_d;
      end
      2'b01: begin
        r_c = v_h;
        b_c = v_v;
      end
      2'b10: begin
        r_c = v_v;
        b_c = v_h;
      end
      default: begin
        r_c = v_d;
        b_c = rc_d[5];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q    <= 1'b0;
      y_q    <= 1'b0;
      s1_raw <= '0;
      s1_g   <= '0;
      for (int i = 1; i <= 5; i++) ph_d[i] <= '0;
      for (int i = 2; i <= 5; i++) begin
        gc_d[i] <= '0;
        rc_d[i] <= '0;
      end
      s2_dl  <= '0;
      s2_dr  <= '0;
      s2_du  <= '0;
      s2_dd  <= '0;
      s2_d00 <= '0;
      s2_d02 <= '0;
      s2_d20 <= '0;
      s2_d22 <= '0;
      s2_xn  <= '0;
      s2_xp  <= '0;
      s2_gn  <= '0;
      s2_gp  <= '0;
      s3_h   <= '0;
      s3_v   <= '0;
      s3_sn  <= '0;
      s3_sp  <= '0;
      s3_axn <= '0;
      s3_agn <= '0;
      s3_axp <= '0;
      s3_agp <= '0;
      s4_h   <= '0;
      s4_v   <= '0;
      s4_sn  <= '0;
      s4_sp  <= '0;
      s4_dn  <= '0;
      s4_dp  <= '0;
      s4_sa  <= '0;
      s5_th  <= '0;
      s5_tv  <= '0;
      s5_td  <= '0;
      out_raw <= '0;
      out_r   <= '0;
      out_g   <= '0;
      out_b   <= '0;
    end else if (cke) begin
      x_q     <= x_c;
      y_q     <= y_c;
      // stage 1: capture window
      s1_raw  <= in_raw;
      s1_g    <= in_g;
      ph_d[1] <= {y_c, x_c};
      // stage 2: colour differences and diagonal gradients
      s2_dl   <= px(s1_raw, 3) - px(s1_g, 3);
      s2_dr   <= px(s1_raw, 5) - px(s1_g, 5);
      s2_du   <= px(s1_raw, 1) - px(s1_g, 1);
      s2_dd   <= px(s1_raw, 7) - px(s1_g, 7);
      s2_d00  <= px(s1_raw, 0) - px(s1_g, 0);
      s2_d02  <= px(s1_raw, 2) - px(s1_g, 2);
      s2_d20  <= px(s1_raw, 6) - px(s1_g, 6);
      s2_d22  <= px(s1_raw, 8) - px(s1_g, 8);
      s2_xn   <= px(s1_raw, 0) - px(s1_raw, 8);
      s2_xp   <= px(s1_raw, 2) - px(s1_raw, 6);
      s2_gn   <= (px(s1_g, 4) <<< 1) - px(s1_g, 0) - px(s1_g, 8);
      s2_gp   <= (px(s1_g, 4) <<< 1) - px(s1_g, 2) - px(s1_g, 6);
      gc_d[2] <= s1_g[4*DATA_WIDTH +: DATA_WIDTH];
      rc_d[2] <= s1_raw[4*DATA_WIDTH +: DATA_WIDTH];
      // stage 3: pair sums and magnitudes
      s3_h    <= s2_dl + s2_dr;
      s3_v    <= s2_du + s2_dd;
      s3_sn   <= s2_d00 + s2_d22;
      s3_sp   <= s2_d02 + s2_d20;
      s3_axn  <= abs_s(s2_xn);
      s3_agn  <= abs_s(s2_gn);
      s3_axp  <= abs_s(s2_xp);
      s3_agp  <= abs_s(s2_gp);
      // stage 4: direction costs
      s4_h    <= s3_h;
      s4_v    <= s3_v;
      s4_sn   <= s3_sn;
      s4_sp   <= s3_sp;
      s4_dn   <= s3_axn + s3_agn;
      s4_dp   <= s3_axp + s3_agp;
      s4_sa   <= s3_sn + s3_sp;
      // stage 5: correction terms
      s5_th   <= div2(s4_h);
      s5_tv   <= div2(s4_v);
      s5_td   <= td_c;
      for (int i = 2; i <= 5; i++) ph_d[i] <= ph_d[i-1];
      for (int i = 3; i <= 5; i++) begin
        gc_d[i] <= gc_d[i-1];
        rc_d[i] <= rc_d[i-1];
      end
      // stage 6: clip and route by site
      out_raw <= rc_d[5];
      out_g   <= gc_d[5];
      out_r   <= r_c;
      out_b   <= b_c;
    end
  end

endmodule

// File: tb/tb_jelly_img_demosaic_acpi_rb_calc.sv
// Scoreboard bench for jelly_img_demosaic_acpi_rb_calc.
// Expected pixels are queued on drive and popped six enabled cycles later.
module tb_jelly_img_demosaic_acpi_rb_calc;

  localparam int DW = 10;
  localparam int N  = 9 * DW;

  logic          clk = 1'b0;
  logic          reset;
  logic          cke;
  logic [1:0]    param_phase;
  logic          in_line_first;
  logic          in_pixel_first;
  logic [N-1:0]  in_raw;
  logic [N-1:0]  in_g;
  logic [DW-1:0] out_raw, out_r, out_g, out_b;

  always #5 clk = ~clk;

  jelly_img_demosaic_acpi_rb_calc #(
    .DATA_WIDTH (DW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cke            (cke),
    .param_phase    (param_phase),
    .in_line_first  (in_line_first),
    .in_pixel_first (in_pixel_first),
    .in_raw         (in_raw),
    .in_g           (in_g),
    .out_raw        (out_raw),
    .out_r          (out_r),
    .out_g          (out_g),
    .out_b          (out_b)
  );

  typedef struct {
    int raw;
    int r;
    int g;
    int b;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  exp_t zero = '{0, 0, 0, 0};
  int   n_cmp = 0;
  int   n_err = 0;
  bit   tx, ty;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input exp_t e);
    check({tag, ".raw"}, int'(out_raw), e.raw);
    check({tag, ".r"},   int'(out_r),   e.r);
    check({tag, ".g"},   int'(out_g),   e.g);
    check({tag, ".b"},   int'(out_b),   e.b);
  endtask

  function automatic int clipv(input int v);
    if (v < 0) return 0;
    if (v > 1023) return 1023;
    return v;
  endfunction

  function automatic int d2(input int v);
`ifdef JELLY_IMG_DEMOSAIC_ACPI_RB_ROUND_EN
    return (v + 1) >>> 1;
`else
    return v >>> 1;
`endif
  endfunction

  function automatic int d4(input int v);
`ifdef JELLY_IMG_DEMOSAIC_ACPI_RB_ROUND_EN
    return (v + 2) >>> 2;
`else
    return v >>> 2;
`endif
  endfunction

  function automatic int absi(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic exp_t model(input logic [N-1:0] rw,
                                 input logic [N-1:0] gw,
                                 input logic [1:0] ph);
    int   X[9];
    int   G[9];
    int   gc, dn, dp, dg, hh, vv;
    exp_t e;
    for (int i = 0; i < 9; i++) begin
      X[i] = int'(rw[i*DW +: DW]);
      G[i] = int'(gw[i*DW +: DW]);
    end
    gc = G[4];
    dn = absi(X[0] - X[8]) + absi(2 * gc - G[0] - G[8]);
    dp = absi(X[2] - X[6]) + absi(2 * gc - G[2] - G[6]);
    if (dn < dp)
      dg = gc + d2((X[0] - G[0]) + (X[8] - G[8]));
    else if (dn > dp)
      dg = gc + d2((X[2] - G[2]) + (X[6] - G[6]));
    else
      dg = gc + d4((X[0] - G[0]) + (X[8] - G[8])
                 + (X[2] - G[2]) + (X[6] - G[6]));
    hh = gc + d2((X[3] - G[3]) + (X[5] - G[5]));
    vv = gc + d2((X[1] - G[1]) + (X[7] - G[7]));
    e.raw = X[4];
    e.g   = gc;
    case (ph)
      2'b00:   begin e.r = X[4];       e.b = clipv(dg); end
      2'b01:   begin e.r = clipv(hh);  e.b = clipv(vv); end
      2'b10:   begin e.r = clipv(vv);  e.b = clipv(hh); end
      default: begin e.r = clipv(dg);  e.b = X[4];      end
    endcase
    return e;
  endfunction

  function automatic logic [N-1:0] w9(input int v0, v1, v2,
                                      input int v3, v4, v5,
                                      input int v6, v7, v8);
    logic [N-1:0] w;
    int v[9];
    v = '{v0, v1, v2, v3, v4, v5, v6, v7, v8};
    for (int i = 0; i < 9; i++) w[i*DW +: DW] = DW'(v[i]);
    return w;
  endfunction

  function automatic logic [N-1:0] wrand();
    logic [N-1:0] w;
    for (int i = 0; i < 9; i++) w[i*DW +: DW] = DW'($urandom_range(0, 1023));
    return w;
  endfunction

  task automatic track(input logic pf, input logic lf,
                       input logic [1:0] pp, output logic [1:0] ph);
    if (pf) begin
      tx = pp[0];
      ty = lf ? pp[1] : ~ty;
    end else begin
      tx = ~tx;
    end
    ph = {ty, tx};
  endtask

  task automatic prefill();
    sb.delete();
    repeat (5) sb.push_back(zero);
    tx = 1'b0;
    ty = 1'b0;
  endtask

  task automatic drive(input logic [N-1:0] rw, input logic [N-1:0] gw,
                       input logic pf, input logic lf,
                       input logic [1:0] pp, input exp_t e,
                       input string tag);
    in_raw         = rw;
    in_g           = gw;
    in_pixel_first = pf;
    in_line_first  = lf;
    param_phase    = pp;
    cke            = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    last = sb.pop_front();
    check_out(tag, last);
  endtask

  task automatic send_exp(input logic [N-1:0] rw, input logic [N-1:0] gw,
                          input logic [1:0] pp, input exp_t e,
                          input string tag);
    logic [1:0] ph;
    track(1'b1, 1'b1, pp, ph);
    drive(rw, gw, 1'b1, 1'b1, pp, e, tag);
  endtask

  task automatic send_model(input logic [N-1:0] rw, input logic [N-1:0] gw,
                            input logic pf, input logic lf,
                            input logic [1:0] pp, input string tag);
    logic [1:0] ph;
    track(pf, lf, pp, ph);
    drive(rw, gw, pf, lf, pp, model(rw, gw, ph), tag);
  endtask

  task automatic run_frames(input int nf, input string tag);
    logic [1:0] pp;
    for (int f = 0; f < nf; f++) begin
      pp = 2'($urandom_range(0, 3));
      for (int ln = 0; ln < 3; ln++)
        for (int p = 0; p < 6; p++)
          send_model(wrand(), wrand(), p == 0, (ln == 0) && (p == 0),
                     pp, tag);
    end
  endtask

  logic [1:0] seq_ph [8];
  logic [N-1:0] rw, gw;
  int r028;

  initial begin
    seq_ph = '{2'b11, 2'b10, 2'b11, 2'b10, 2'b01, 2'b00, 2'b01, 2'b00};
`ifdef JELLY_IMG_DEMOSAIC_ACPI_RB_ROUND_EN
    r028 = 551;
`else
    r028 = 550;
`endif
    reset          = 1'b1;
    cke            = 1'b0;
    param_phase    = 2'b00;
    in_line_first  = 1'b0;
    in_pixel_first = 1'b0;
    in_raw         = '0;
    in_g           = '0;
    repeat (2) @(posedge clk);
    #1;
    check_out("rst", zero);
    reset = 1'b0;
    prefill();

    // flat field, every phase
    for (int p = 0; p < 4; p++)
      send_exp(w9(512, 512, 512, 512, 512, 512, 512, 512, 512),
               w9(512, 512, 512, 512, 512, 512, 512, 512, 512),
               2'(p), '{512, 512, 512, 512}, "flat");

    send_exp(w9(0, 300, 0, 600, 450, 701, 0, 300, 0),
             w9(0, 500, 0, 500, 400, 500, 0, 500, 0),
             2'b01, '{450, r028, 400, 200}, "g_rrow");
    send_exp(w9(0, 700, 0, 600, 33, 600, 0, 700, 0),
             w9(0, 700, 0, 500, 1000, 500, 0, 700, 0),
             2'b01, '{33, 1023, 1000, 1000}, "clip_hi");
    send_exp(w9(0, 80, 0, 300, 44, 300, 0, 80, 0),
             w9(0, 80, 0, 500, 50, 500, 0, 80, 0),
             2'b01, '{44, 0, 50, 50}, "clip_lo");
    send_exp(w9(0, 300, 0, 600, 451, 700, 0, 300, 0),
             w9(0, 500, 0, 500, 400, 500, 0, 500, 0),
             2'b10, '{451, 200, 400, 550}, "g_brow");
    send_exp(w9(600, 0, 900, 0, 777, 0, 100, 0, 600),
             w9(500, 0, 500, 0, 500, 0, 500, 0, 500),
             2'b11, '{777, 600, 500, 777}, "diag_n");
    send_exp(w9(100, 0, 650, 0, 321, 0, 650, 0, 900),
             w9(500, 0, 500, 0, 500, 0, 500, 0, 500),
             2'b00, '{321, 321, 500, 650}, "diag_p");
    send_exp(w9(600, 0, 600, 0, 123, 0, 600, 0, 600),
             w9(500, 0, 500, 0, 500, 0, 500, 0, 500),
             2'b00, '{123, 123, 500, 600}, "diag_eq");

    // two lines of four, starting at a B site
    for (int i = 0; i < 8; i++) begin
      logic [1:0] ph;
      rw = wrand();
      gw = wrand();
      track(i % 4 == 0, i == 0, 2'b11, ph);
      drive(rw, gw, i % 4 == 0, i == 0, 2'b11,
            model(rw, gw, seq_ph[i]), "phseq");
    end

    run_frames(2, "rand");

    // stall: outputs hold, stream resumes afterwards
    cke = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_raw         = wrand();
      in_g           = wrand();
      in_pixel_first = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check_out("hold", last);
    end
    run_frames(1, "resume");

    // reset with cke low drops in-flight pixels and phase state
    reset = 1'b1;
    cke   = 1'b0;
    @(posedge clk);
    #1;
    check_out("mrst", zero);
    reset = 1'b0;
    prefill();
    for (int i = 0; i < 3; i++)
      send_model(wrand(), wrand(), 1'b0, 1'b0, 2'b11, "post_rst");
    run_frames(2, "rand2");
    for (int i = 0; i < 5; i++)
      send_model(wrand(), wrand(), 1'b0, 1'b0, 2'b00, "drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
